mc_alu_sequencer: RTL
=====================

Name: mc_alu_sequencer

Overview:
- Multi-cycle main control FSM for the MIPS-lite datapath.
- Initiator side of the ALU interface: issues the 3-bit ALU control line (gin) every cycle and consumes the ALU zero flag (zout).
- Decodes op/funct from the instruction register and sequences fetch/decode/execute/memory/writeback steps.
- Drives all datapath enables: PC, IR, memory, register file and muxes.

Parameters:
- TRAP_ON_ILLEGAL, 1: 1 = an illegal op/funct enters TRAP; 0 = an illegal instruction retires as a NOP (returns to FETCH).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  6  instruction[31:26] from the IR
- funct  in  6  instruction[5:0] from the IR
- zout  in  1  ALU zero flag
- gin  out  3  ALU control line: 010 add, 110 sub, 111 slt, 000 and, 001 or
- pc_en  out  1  PC load enable, branch resolution included
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  write data: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A input: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- pcsource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump (unused, never driven)
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  sticky illegal-instruction flag
- state_dbg  out  4  current state encoding

Behaviour:
- State register is 4 bits. Encodings: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, BR=9, IEXEC=10, IWB=11, TRAP=15.
- Reset: rst_n low at a clock edge gives state=RST and illegal=0, regardless of the current state, including mid-instruction.
- RST state: every output is 0 except gin=010 and state_dbg=0. Next state is FETCH.
- Outputs are Moore-decoded from state. Exceptions: gin in REXEC/RWB depends on funct; pc_en in BR depends on zout/op.
- Any control not listed for a state is 0.
- FETCH: memread=1, irwrite=1, alusrcb=01, gin=010, pc_en=1, pcsource=00 → DECODE.
- DECODE: alusrcb=11, gin=010 (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → REXEC
  - 000100 (beq) or 000101 (bne) → BR
  - 001000 (addi) → IEXEC
  - otherwise illegal
- MEMADR: alusrca=1, alusrcb=10, gin=010 → MEMRD if lw, MEMWR if sw.
- MEMRD: iord=1, memread=1 → MEMWB.
- MEMWB: memtoreg=1, regwrite=1, regdst=0, instr_done=1 → FETCH.
- MEMWR: iord=1, memwrite=1, instr_done=1 → FETCH.
- REXEC: alusrca=1, alusrcb=00, gin from funct:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - any other funct is illegal, detected in DECODE before entering REXEC
- RWB: regdst=1, regwrite=1, gin held at the REXEC value, instr_done=1 → FETCH.
- BR: alusrca=1, alusrcb=00, gin=110, pcsource=01, instr_done=1. pc_en = zout for beq, ~zout for bne. → FETCH.
- IEXEC: alusrca=1, alusrcb=10, gin=010 → IWB.
- IWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1 → FETCH.
- Illegal instruction (detected in DECODE):
  - TRAP_ON_ILLEGAL=1: → TRAP and illegal←1. TRAP holds with all controls 0 until reset.
  - TRAP_ON_ILLEGAL=0: → FETCH with instr_done=1 (NOP); illegal stays 0.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, plus 1 RST cycle after reset.
- memread and memwrite are never both 1. regwrite and memwrite are never both 1.
- Unreachable encodings (12–14) → RST on the next edge.

Test Plan:
- Reset mid-lw: assert rst_n=0 in MEMRD → next edge state=0 with all strobes 0; after release, FETCH one cycle later with memread=1, irwrite=1, pc_en=1, gin=010.
- op=000000, funct=101010 → states 1,2,7,8; gin=111 in REXEC and RWB; regwrite=1, regdst=1 only in RWB; instr_done pulses once.
- lw (op=100011) → states 1,2,3,4,5, 5 cycles; iord=1 in MEMRD; memtoreg=1, regwrite=1 in MEMWB. sw (op=101011) → 1,2,3,6 with memwrite=1 only in MEMWR.
- beq: zout=1 in BR → pc_en=1, pcsource=01, gin=110; zout=0 → pc_en=0. bne inverts both cases.
- Illegal: op=111111 with TRAP_ON_ILLEGAL=1 → state 15, illegal=1, held 20 cycles, then cleared only by reset. With TRAP_ON_ILLEGAL=0 → back to FETCH with illegal=0. Repeat with op=0, funct=000111.
- Back-to-back addi then sub: IEXEC gin=010, alusrcb=10; IWB regwrite=1, regdst=0; next REXEC gin=110; total 8 cycles between FETCH entries.

Source files
------------

// File: rtl/mc_alu_sequencer_if.sv
// ALU control link between the main sequencer and the ALU.
// The sequencer issues the ALU opcode and reads back the zero flag.
interface mc_alu_sequencer_if;
  logic [2:0] gin;
  logic       zout;

  modport master (output gin, input zout);
  modport slave  (input gin, output zout);
endinterface

// File: rtl/mc_alu_sequencer.sv
// mc_alu_sequencer: multi-cycle MIPS-lite main control FSM.
// Sequences each instruction and drives all datapath enables.
module mc_alu_sequencer #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  mc_alu_sequencer_if.master alu,
  output logic       pc_en,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    BR     = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    TRAP   = 4'd15
  } state_t;

  typedef struct packed {
    logic [2:0] gin;
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       illegal_q, illegal_d;
  logic       is_mem, is_r, is_br, is_addi;
  logic       f_ok, ill_dec;
  logic [2:0] f_gin, r_gin;

  assign is_mem  = (op == 6'b100011) | (op == 6'b101011);
  assign is_r    = (op == 6'b000000);
  assign is_br   = (op == 6'b000100) | (op == 6'b000101);
  assign is_addi = (op == 6'b001000);

  always_comb begin
    f_ok  = 1'b1;
    f_gin = 3'b010;
    case (funct)
      6'b100000: f_gin = 3'b010;
      6'b100010: f_gin = 3'b110;
      6'b100100: f_gin = 3'b000;
      6'b100101: f_gin = 3'b001;
      6'b101010: f_gin = 3'b111;
      default:   f_ok  = 1'b0;
    endcase
  end

  assign ill_dec = !(is_mem | (is_r & f_ok) | is_br | is_addi);

  // Control word for the state being entered; registered one edge ahead.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] rg);
    ctrl_t c;
    c     = '0;
    c.gin = 3'b010;
    case (s)
      RST: ;
      FETCH: begin
        c.memread = 1'b1;
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.pc_en   = 1'b1;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      MEMWB: begin
        c.memtoreg   = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      MEMWR: begin
        c.iord       = 1'b1;
        c.memwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      REXEC: begin
        c.alusrca = 1'b1;
        c.gin     = rg;
      end
      RWB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.gin        = rg;
        c.instr_done = 1'b1;
      end
      BR: begin
        c.alusrca    = 1'b1;
        c.gin        = 3'b110;
        c.pcsource   = 2'b01;
        c.instr_done = 1'b1;
      end
      IEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      IWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      TRAP:    c = '0;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = RST;
    case (state_q)
      RST:    state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (ill_dec) begin
          state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        end else begin
          unique case (1'b1)
            is_mem:  state_d = MEMADR;
            is_r:    state_d = REXEC;
            is_br:   state_d = BR;
            default: state_d = IEXEC;
          endcase
        end
      end
      MEMADR: state_d = op[3] ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      REXEC:  state_d = RWB;
      IEXEC:  state_d = IWB;
      MEMWB, MEMWR, RWB, BR, IWB: state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = RST;
    endcase
    // funct is only trusted while leaving DECODE; RWB reuses REXEC's code
    r_gin     = (state_q == DECODE) ? f_gin : ctrl_q.gin;
    ctrl_d    = ctrl_of(state_d, r_gin);
    illegal_d = illegal_q | (state_d == TRAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RST;
      ctrl_q    <= ctrl_of(RST, 3'b010);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu.gin    = ctrl_q.gin;
  assign pc_en      = ctrl_q.pc_en |
                      ((state_q == BR) & (alu.zout ^ op[0]));
  assign iord       = ctrl_q.iord;
  assign memread    = ctrl_q.memread;
  assign memwrite   = ctrl_q.memwrite;
  assign irwrite    = ctrl_q.irwrite;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign regwrite   = ctrl_q.regwrite;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsource   = ctrl_q.pcsource;
  assign instr_done = ctrl_q.instr_done |
                      ((state_q == DECODE) & ill_dec & !TRAP_ON_ILLEGAL);
  assign illegal    = illegal_q;
  assign state_dbg  = state_q;

endmodule
